vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 15 +
 rtl/vram_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and screen-map constants for the video RAM arbiter.
// The owner enum names who holds the RAM data phase in the cycle after a grant.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } owner_e;

  localparam logic [12:0] PIX_BASE  = 13'h0000;
  localparam logic [12:0] ATTR_BASE = 13'h1800;
  localparam logic [12:0] VRAM_TOP  = 13'h1AFF;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, CPU is stalled via cpu_wait.
// Optional starvation guard (VRAM_ARB_STARVE_GUARD_EN) forces a CPU slot after MAX_VID_BURST video grants.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 8,
  parameter int MAX_VID_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              vid_miss
);

  owner_e            state_q, state_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic cpu_elig;
  logic cpu_grant;
  logic vid_grant;
  logic force_cpu;
  logic cpu_rd_ack;

  // Ack/rvalid are gated by reset so an access in flight when reset hits never completes.
  assign cpu_ack    = rst_n && (state_q == CPU);
  assign vid_rvalid = rst_n && (state_q == VID);
  assign cpu_rd_ack = cpu_ack && !cpu_wr_q;
  assign cpu_wait   = cpu_req && !cpu_ack;
  assign cpu_elig   = rst_n && cpu_req && !cpu_ack;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_VID_BURST + 1);

  logic [CNT_W-1:0] burst_q, burst_d;

  assign force_cpu = (burst_q == CNT_W'(MAX_VID_BURST));
  assign vid_miss  = force_cpu && cpu_elig && vid_req;

  always_comb begin
    burst_d = burst_q;
    if (!cpu_req || cpu_grant) begin
      burst_d = '0;
    end else if (vid_grant && cpu_elig && !force_cpu) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign force_cpu = 1'b0;
  assign vid_miss  = 1'b0;
`endif

  always_comb begin
    vid_grant = 1'b0;
    cpu_grant = 1'b0;
    if (rst_n) begin
      if (cpu_elig && (force_cpu || !vid_req)) begin
        cpu_grant = 1'b1;
      end else if (vid_req) begin
        vid_grant = 1'b1;
      end
    end
  end

  assign vid_gnt = vid_grant;

  // Address phase is driven straight from the winner; idle cycles park the bus at zero.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    state_d   = IDLE;
    cpu_wr_d  = 1'b0;
    if (vid_grant) begin
      ram_addr = vid_addr;
      state_d  = VID;
    end else if (cpu_grant) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      state_d  = CPU;
      cpu_wr_d = cpu_we;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  assign vid_rdata = vid_rvalid ? ram_rdata : vid_rdata_q;
  assign cpu_rdata = cpu_rd_ack ? ram_rdata : cpu_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cpu_wr_q    <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cpu_wr_q <= cpu_wr_d;
      if (vid_rvalid) begin
        vid_rdata_q <= ram_rdata;
      end
      if (cpu_rd_ack) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: cycle table plus hand-built sequences, read data checked against a queue of expectations.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          vid_miss;

  always #20 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .vid_miss(vid_miss)
  );

  // Synchronous RAM: read data appears one cycle after the address.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]     = 8'(a) ^ 8'h3C;
      exp_mem[a] = 8'(a) ^ 8'h3C;
    end
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic          rd;
    logic [DW-1:0] d;
  } sb_t;

  sb_t vq[$];
  sb_t cq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs, queue expected read data, check outputs at the falling edge.
  task automatic step(input string tag,
                      input logic vr, input logic [AW-1:0] va,
                      input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic gv, input logic gc, input logic ack, input logic rv, input logic miss);
    logic [AW-1:0] e_addr;
    sb_t e;
    vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    if (gv) vq.push_back('{1'b1, exp_mem[va]});
    if (gc) begin
      if (cw) exp_mem[ca] = cd;
      cq.push_back('{!cw, exp_mem[ca]});
    end
    e_addr = gv ? va : (gc ? ca : '0);
    @(negedge clk);
    chk({tag, " vid_gnt"},    32'(vid_gnt),    32'(gv));
    chk({tag, " ram_we"},     32'(ram_we),     32'(gc & cw));
    chk({tag, " ram_addr"},   32'(ram_addr),   32'(e_addr));
    if (gc && cw) chk({tag, " ram_wdata"}, 32'(ram_wdata), 32'(cd));
    chk({tag, " cpu_ack"},    32'(cpu_ack),    32'(ack));
    chk({tag, " vid_rvalid"}, 32'(vid_rvalid), 32'(rv));
    chk({tag, " vid_miss"},   32'(vid_miss),   32'(miss));
    chk({tag, " cpu_wait"},   32'(cpu_wait),   32'(cr & ~ack));
    if (vid_rvalid) begin
      if (vq.size() == 0) chk({tag, " vid_sb_empty"}, 32'(vid_rvalid), 32'd0);
      else begin
        e = vq.pop_front();
        chk({tag, " vid_rdata"}, 32'(vid_rdata), 32'(e.d));
      end
    end
    if (cpu_ack) begin
      if (cq.size() == 0) chk({tag, " cpu_sb_empty"}, 32'(cpu_ack), 32'd0);
      else begin
        e = cq.pop_front();
        if (e.rd) chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(e.d));
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          vr;
    logic [AW-1:0] va;
    logic          cr;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          gv;
    logic          gc;
    logic          ack;
    logic          rv;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int g_cyc;
    int a_cyc;
    logic gv, gc, pgv, pgc, miss;
    string tag;

    //            vr  va               cr cw ca                cd     gv gc ack rv
    tbl[0]  = '{1'b0, PIX_BASE,       1'b0, 1'b0, PIX_BASE,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 13'h0010,       1'b0, 1'b0, PIX_BASE,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 13'h0011,       1'b0, 1'b0, PIX_BASE,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, PIX_BASE,       1'b1, 1'b1, ATTR_BASE, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 13'h0012,       1'b1, 1'b1, ATTR_BASE, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, PIX_BASE,       1'b1, 1'b0, ATTR_BASE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, PIX_BASE,       1'b0, 1'b0, ATTR_BASE, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, ATTR_BASE,      1'b1, 1'b0, 13'h0001,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, PIX_BASE,       1'b1, 1'b0, 13'h0001,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, PIX_BASE,       1'b1, 1'b0, 13'h0001,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, PIX_BASE,       1'b0, 1'b0, 13'h0001,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset: video request present but nothing may be granted.
    rst_n = 1'b0; vid_req = 1'b1; vid_addr = 13'h0005;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst vid_gnt", 32'(vid_gnt), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rst cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst vid_rdata", 32'(vid_rdata), 32'd0);
    chk("rst cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst vid_miss", 32'(vid_miss), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      step(tag, tbl[i].vr, tbl[i].va, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
           tbl[i].gv, tbl[i].gc, tbl[i].ack, tbl[i].rv, 1'b0);
    end

    // Continuous video with a CPU read pending.
`ifdef VRAM_ARB_STARVE_GUARD_EN
    g_cyc = 4;
`else
    g_cyc = 10;
`endif
    a_cyc = g_cyc + 1;
    pgv = 1'b0; pgc = 1'b0;
    for (int i = 0; i < 13; i++) begin
      gc   = (i == g_cyc);
      gv   = (i < 10) && !gc;
      miss = gc && (i < 10);
      tag  = $sformatf("burst%0d", i);
      step(tag, (i < 10), 13'(13'h0200 + i), (i <= a_cyc), 1'b0, 13'h0100, 8'h00,
           gv, gc, pgc, pgv, miss);
      pgv = gv; pgc = gc;
    end

    // Reset one cycle after a CPU read grant: the read is dropped.
    step("rstmid grant", 1'b0, PIX_BASE, 1'b1, 1'b0, 13'h0003, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 13'h0007;
    vq.delete(); cq.delete();
    @(negedge clk);
    chk("rstmid cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rstmid vid_gnt", 32'(vid_gnt), 32'd0);
    chk("rstmid ram_we", 32'(ram_we), 32'd0);
    chk("rstmid vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rstmid ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid vid_rdata", 32'(vid_rdata), 32'd0);
    chk("rstmid cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rstmid cpu_ack2", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("post idle",  1'b0, PIX_BASE, 1'b0, 1'b0, PIX_BASE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post wr",    1'b0, PIX_BASE, 1'b1, 1'b1, VRAM_TOP, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post wrack", 1'b0, PIX_BASE, 1'b0, 1'b1, VRAM_TOP, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post rd",    1'b0, PIX_BASE, 1'b1, 1'b0, VRAM_TOP, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post rdack", 1'b1, VRAM_TOP, 1'b1, 1'b0, VRAM_TOP, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post vrv",   1'b0, PIX_BASE, 1'b0, 1'b0, VRAM_TOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    chk("sb vid leftover", 32'(vq.size()), 32'd0);
    chk("sb cpu leftover", 32'(cq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
